// File: rtl/cpu4_wbck_arb.sv
// Write-back arbiter for the cpu4 register file write port (LSU over ALU with
// an ALU anti-starvation counter) plus the per-register outstanding-load scoreboard.
module cpu4_wbck_arb #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int RFREG_NUM   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wb_valid,
  output logic                   alu_wb_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]        alu_wb_data,
  input  logic                   lsu_wb_valid,
  output logic                   lsu_wb_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]        lsu_wb_data,
  input  logic                   lsu_issue_valid,
  input  logic [RFIDX_WIDTH-1:0] lsu_issue_rd,
  input  logic [RFIDX_WIDTH-1:0] chk_rs1_idx,
  input  logic [RFIDX_WIDTH-1:0] chk_rs2_idx,
  input  logic [RFIDX_WIDTH-1:0] chk_rd_idx,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   rd_busy,
  output logic                   rd_wen,
  output logic [RFIDX_WIDTH-1:0] rd_idx,
  output logic [XLEN-1:0]        rd_data,
  output logic                   sb_err
);

  // Handshake: a transfer happens when *_wb_valid and *_wb_ready are both high;
  // ready is the grant, so it never rises without valid, and a requester that
  // is not granted keeps its rd/data stable.

  logic [1:0]             alu_wait_cnt_q, alu_wait_cnt_d;
  logic                   rd_wen_q, rd_wen_d;
  logic [RFIDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [XLEN-1:0]        rd_data_q, rd_data_d;
  logic                   lsu_wen_q, lsu_wen_d;
  logic [RFREG_NUM-1:1]   sb_q, sb_d;
  logic                   sb_err_q, sb_err_d;

  logic                   alu_pri;
  logic                   grant_alu;
  logic                   grant_lsu;
  logic [RFREG_NUM-1:0]   sb_full;
  logic [RFREG_NUM-1:0]   sb_next;
  logic                   clr_hit;

  always_comb begin
    alu_pri   = (alu_wait_cnt_q == 2'd3);
    grant_alu = ~rst & alu_wb_valid & (alu_pri | ~lsu_wb_valid);
    grant_lsu = ~rst & lsu_wb_valid & ~grant_alu;

    alu_wait_cnt_d = 2'd0;
    if (alu_wb_valid && !grant_alu) begin
      alu_wait_cnt_d = alu_pri ? 2'd3 : alu_wait_cnt_q + 2'd1;
    end

    rd_wen_d  = 1'b0;
    lsu_wen_d = 1'b0;
    rd_idx_d  = rd_idx_q;
    rd_data_d = rd_data_q;
    if (grant_lsu) begin
      rd_idx_d  = lsu_wb_rd;
      rd_data_d = lsu_wb_data;
      rd_wen_d  = (lsu_wb_rd != '0);
      lsu_wen_d = (lsu_wb_rd != '0);
    end else if (grant_alu) begin
      rd_idx_d  = alu_wb_rd;
      rd_data_d = alu_wb_data;
      rd_wen_d  = (alu_wb_rd != '0);
    end
  end

  // A re-issue landing on the very edge that commits the previous load to the
  // same register is a legal reuse, not a busy-register violation; set wins.
  always_comb begin
    sb_full  = {sb_q, 1'b0};
    sb_next  = sb_full;
    clr_hit  = 1'b0;
    sb_err_d = sb_err_q;
    if (lsu_wen_q) begin
      sb_next[rd_idx_q] = 1'b0;
      clr_hit           = (rd_idx_q == lsu_issue_rd);
    end
    if (lsu_issue_valid && lsu_issue_rd != '0) begin
      if (sb_full[lsu_issue_rd] && !clr_hit) begin
        sb_err_d = 1'b1;
      end
      sb_next[lsu_issue_rd] = 1'b1;
    end
    sb_d = sb_next[RFREG_NUM-1:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wait_cnt_q <= 2'd0;
      rd_wen_q       <= 1'b0;
      rd_idx_q       <= '0;
      rd_data_q      <= '0;
      lsu_wen_q      <= 1'b0;
      sb_q           <= '0;
      sb_err_q       <= 1'b0;
    end else begin
      alu_wait_cnt_q <= alu_wait_cnt_d;
      rd_wen_q       <= rd_wen_d;
      rd_idx_q       <= rd_idx_d;
      rd_data_q      <= rd_data_d;
      lsu_wen_q      <= lsu_wen_d;
      sb_q           <= sb_d;
      sb_err_q       <= sb_err_d;
    end
  end

  assign alu_wb_ready = grant_alu;
  assign lsu_wb_ready = grant_lsu;
  assign rs1_busy     = sb_full[chk_rs1_idx];
  assign rs2_busy     = sb_full[chk_rs2_idx];
  assign rd_busy      = sb_full[chk_rd_idx];
  assign rd_wen       = rd_wen_q;
  assign rd_idx       = rd_idx_q;
  assign rd_data      = rd_data_q;
  assign sb_err       = sb_err_q;

endmodule

// File: tb/tb_cpu4_wbck_arb.sv
// Bench for cpu4_wbck_arb: directed scenarios then protocol-respecting random
// traffic, checked against a cycle-level reference model and a write scoreboard.
module tb_cpu4_wbck_arb;

  localparam int XLEN = 32;
  localparam int IW   = 5;
  localparam int NREG = 32;

  logic            clk;
  logic            rst;
  logic            alu_wb_valid, alu_wb_ready;
  logic [IW-1:0]   alu_wb_rd;
  logic [XLEN-1:0] alu_wb_data;
  logic            lsu_wb_valid, lsu_wb_ready;
  logic [IW-1:0]   lsu_wb_rd;
  logic [XLEN-1:0] lsu_wb_data;
  logic            lsu_issue_valid;
  logic [IW-1:0]   lsu_issue_rd;
  logic [IW-1:0]   chk_rs1_idx, chk_rs2_idx, chk_rd_idx;
  logic            rs1_busy, rs2_busy, rd_busy;
  logic            rd_wen;
  logic [IW-1:0]   rd_idx;
  logic [XLEN-1:0] rd_data;
  logic            sb_err;

  cpu4_wbck_arb #(.XLEN(XLEN), .RFIDX_WIDTH(IW), .RFREG_NUM(NREG)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_issue_valid(lsu_issue_valid), .lsu_issue_rd(lsu_issue_rd),
    .chk_rs1_idx(chk_rs1_idx), .chk_rs2_idx(chk_rs2_idx), .chk_rd_idx(chk_rd_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .rd_wen(rd_wen), .rd_idx(rd_idx), .rd_data(rd_data), .sb_err(sb_err)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters, scoreboard, reference model ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [68:0] exp_q[$];      // {due cycle, rd index, data} of expected register writes
  logic [36:0] clr_q[$];      // {cycle whose closing edge clears the bit, rd index}
  bit [NREG-1:0] mdl_busy;
  bit            mdl_err;
  int            alu_waited;  // consecutive cycles the ALU has been left waiting

  int          out_q[$];      // loads issued and not yet written back
  bit          got_a, got_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor: pops expected writes when rd_wen shows ----------------
  initial begin
    logic [68:0] e;
    logic        due;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rd_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: actual rd_wen=1 idx=%0d data=%0h, expected no write (cycle %0d)",
                   rd_idx, rd_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", cyc, e[68:37]);
          chk("wr_idx", 32'(rd_idx), 32'(e[36:32]));
          chk("wr_data", rd_data, e[31:0]);
        end
      end else begin
        due = (exp_q.size() > 0) && (int'(exp_q[0][68:37]) <= cyc);
        chk("rd_wen", 32'(rd_wen), 32'(due));
        if (due) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver: one cycle of stimulus plus model update ----------------
  task automatic step(input bit r,
                      input bit av, input logic [IW-1:0] ard, input logic [XLEN-1:0] ad,
                      input bit lv, input logic [IW-1:0] lrd, input logic [XLEN-1:0] ld,
                      input bit iv, input logic [IW-1:0] ird,
                      input logic [IW-1:0] c1, input logic [IW-1:0] c2, input logic [IW-1:0] c3);
    bit ga, gl;
    bit [NREG-1:0] busy_before, clr_now;
    @(negedge clk);
    rst = r;
    alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ld;
    lsu_issue_valid = iv; lsu_issue_rd = ird;
    chk_rs1_idx = c1; chk_rs2_idx = c2; chk_rd_idx = c3;
    #1;
    ga = !r && av && (!lv || alu_waited >= 3);
    gl = !r && lv && !ga;
    chk("alu_wb_ready", 32'(alu_wb_ready), 32'(ga));
    chk("lsu_wb_ready", 32'(lsu_wb_ready), 32'(gl));
    chk("rs1_busy", 32'(rs1_busy), 32'(mdl_busy[c1]));
    chk("rs2_busy", 32'(rs2_busy), 32'(mdl_busy[c2]));
    chk("rd_busy", 32'(rd_busy), 32'(mdl_busy[c3]));
    chk("sb_err", 32'(sb_err), 32'(mdl_err));
    if (r) begin
      mdl_busy   = '0;
      mdl_err    = 1'b0;
      alu_waited = 0;
      clr_q.delete();
    end else begin
      alu_waited  = (av && !ga) ? alu_waited + 1 : 0;
      busy_before = mdl_busy;
      clr_now     = '0;
      while (clr_q.size() > 0 && int'(clr_q[0][36:5]) <= cyc) begin
        clr_now[clr_q[0][4:0]]  = 1'b1;
        mdl_busy[clr_q[0][4:0]] = 1'b0;
        void'(clr_q.pop_front());
      end
      if (iv && ird != 0) begin
        if (busy_before[ird] && !clr_now[ird]) mdl_err = 1'b1;
        mdl_busy[ird] = 1'b1;
      end
      if (ga && ard != 0) exp_q.push_back({32'(cyc + 1), ard, ad});
      if (gl && lrd != 0) begin
        exp_q.push_back({32'(cyc + 1), lrd, ld});
        clr_q.push_back({32'(cyc + 1), lrd});
      end
    end
    got_a = ga;
    got_l = gl;
  endtask

  task automatic idle(input int n, input logic [IW-1:0] c);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, c, c, c);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0]      pattern;
    bit              a_v, l_v, iv;
    logic [IW-1:0]   a_rd, l_rd, ird;
    logic [XLEN-1:0] a_data, l_data;

    rst = 1'b1;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    lsu_issue_valid = 0; lsu_issue_rd = 0;
    chk_rs1_idx = 0; chk_rs2_idx = 0; chk_rd_idx = 0;
    mdl_busy = '0; mdl_err = 0; alu_waited = 0;
    got_a = 0; got_l = 0;

    // Reset values
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_rd_idx", 32'(rd_idx), 0);
    chk("rst_rd_data", rd_data, 0);

    // Lone ALU write: ready same cycle, write visible next cycle
    step(0, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // Continuous contention: LSU wins three cycles, ALU wins the fourth
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 7, 7);
    pattern = '0;
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 3, 32'hAAAA_0003, 1, 7, 32'h5555_0007, 0, 0, 7, 3, 0);
      pattern[k] = got_a;
    end
    chk("starve_pattern", 32'(pattern), 32'h08);
    idle(2, 7);

    // Load to x9: busy from next cycle, through the rd_wen cycle, clear after
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 9);
    idle(1, 9);
    step(0, 0, 0, 0, 1, 9, 32'h0000_0099, 0, 0, 9, 9, 9);
    idle(3, 9);

    // x0: ALU write accepted but not committed; load to x0 never busy
    step(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(2, 0);

    // Set/clear on one edge for x4, then a true busy re-issue
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 4, 4);
    idle(1, 4);
    step(0, 0, 0, 0, 1, 4, 32'h4444_0004, 0, 0, 4, 4, 4);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 4, 4);
    idle(2, 4);
    chk("busy4_after_reissue", 32'(rd_busy), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 4, 4, 4);
    idle(3, 4);
    chk("sb_err_sticky", 32'(sb_err), 1);

    // Reset alongside an ALU request: nothing accepted, state cleared
    step(1, 1, 6, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 4, 4, 4);
    idle(2, 4);
    chk("post_rst_busy4", 32'(rd_busy), 0);
    chk("post_rst_err", 32'(sb_err), 0);

    // Random traffic obeying the hold-while-not-granted rule
    out_q.delete();
    a_v = 0; l_v = 0; a_rd = 0; l_rd = 0; a_data = 0; l_data = 0;
    got_a = 0; got_l = 0;
    for (int n = 0; n < 800; n++) begin
      if (!a_v || got_a) begin
        a_v    = ($urandom_range(0, 3) != 0);
        a_rd   = IW'($urandom_range(0, NREG - 1));
        a_data = $urandom;
      end
      if (!l_v && out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        l_v    = 1;
        l_rd   = IW'(out_q[0]);
        l_data = $urandom;
      end
      iv  = 0;
      ird = IW'($urandom_range(0, NREG - 1));
      if ($urandom_range(0, 2) == 0 && out_q.size() < 4 && (ird == 0 || !mdl_busy[ird])) begin
        iv = 1;
        out_q.push_back(int'(ird));
      end
      step(0, a_v, a_rd, a_data, l_v, l_rd, l_data, iv, ird,
           IW'($urandom_range(0, NREG - 1)), IW'($urandom_range(0, NREG - 1)),
           IW'($urandom_range(0, NREG - 1)));
      if (got_l) begin
        void'(out_q.pop_front());
        l_v = 0;
      end
    end

    idle(4, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
